vga_text_renderer: RTL and testbench



---
 rtl/vga_text_renderer_pkg.sv | 33 +++
 rtl/vga_text_renderer_font_rom.sv | 42 ++++
 rtl/vga_text_renderer.sv | 155 +++++++++++++++
 tb/tb_vga_text_renderer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_renderer_pkg.sv
// Shared constants, cell word layout and colour table for the text-mode
// pixel stage.
package vga_text_renderer_pkg;

    localparam int COLS           = 80;
    localparam int ROWS           = 30;
    localparam int FONT_W         = 8;
    localparam int FONT_H         = 16;
    localparam int CELL_COUNT     = COLS * ROWS;
    localparam int RENDER_LATENCY = 3;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] ch;
    } cell_t;

    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic logic [11:0] palette(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_text_renderer_font_rom.sv
// 4096x8 glyph ROM, address {char, row}, one-cycle registered read.
// Codes without an entry render as blank cells.
module font_rom (
    input  logic        clk,
    input  logic [11:0] i_addr,
    output logic [7:0]  o_data
);

    logic [7:0] w_data;

    always_comb begin
        w_data = 8'h00;
        case (i_addr)
            12'h412: w_data = 8'h10;
            12'h413: w_data = 8'h38;
            12'h414: w_data = 8'h6C;
            12'h415: w_data = 8'hC6;
            12'h416: w_data = 8'hC6;
            12'h417: w_data = 8'hFE;
            12'h418: w_data = 8'hC6;
            12'h419: w_data = 8'hC6;
            12'h41A: w_data = 8'hC6;
            12'h41B: w_data = 8'hC6;
            12'h582: w_data = 8'hC6;
            12'h583: w_data = 8'hC6;
            12'h584: w_data = 8'h6C;
            12'h585: w_data = 8'h7C;
            12'h586: w_data = 8'h38;
            12'h587: w_data = 8'h38;
            12'h588: w_data = 8'h7C;
            12'h589: w_data = 8'h6C;
            12'h58A: w_data = 8'hC6;
            12'h58B: w_data = 8'hC6;
            default: w_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        o_data <= w_data;
    end

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel stage: cell RAM -> font ROM -> palette, three register
// stages with syncs delayed alongside so pixel and sync stay aligned.
module vga_text_renderer
    import vga_text_renderer_pkg::*;
#(
    parameter int   COLS         = vga_text_renderer_pkg::COLS,
    parameter int   ROWS         = vga_text_renderer_pkg::ROWS,
    parameter int   FONT_W       = vga_text_renderer_pkg::FONT_W,
    parameter int   FONT_H       = vga_text_renderer_pkg::FONT_H,
    parameter int   BLINK_FRAMES = 32,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic        clock25MHz,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        canDisplayImage,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        cursor_en,
    input  logic [11:0] cursor_addr,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync
);

    localparam int XB    = $clog2(FONT_W);
    localparam int YB    = $clog2(FONT_H);
    localparam int NCELL = COLS * ROWS;
    localparam int CW    = $clog2(BLINK_FRAMES);

    logic [11:0]    w_row;
    logic [11:0]    w_col;
    logic [11:0]    w_cell_addr;
    logic           w_wr_ok;
    logic           w_vs_start;
    logic           w_pix;
    logic [11:0]    w_rgb;

    cell_t          r_ram [NCELL];
    cell_t          r_cell;

    logic           r0_de, r0_hs, r0_vs, r0_cur;
    logic [XB-1:0]  r0_xcol;
    logic [YB-1:0]  r0_yrow;

    logic           r1_de, r1_hs, r1_vs, r1_curline;
    logic [XB-1:0]  r1_xcol;
    logic [3:0]     r1_fg, r1_bg;
    logic [7:0]     w_glyph;

    logic           r_vs_prev;
    logic [CW-1:0]  r_blink_cnt;
    logic           r_blink_vis;

    assign w_row       = 12'(y >> YB);
    assign w_col       = 12'(x >> XB);
    assign w_cell_addr = 12'(w_row * 12'(COLS)) + w_col;
    assign w_wr_ok     = wr_en && (wr_addr < 12'(NCELL));
    assign w_vs_start  = (r_vs_prev == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

    // Non-blocking read alongside the write gives read-first behaviour.
    always_ff @(posedge clock25MHz) begin
        if (w_wr_ok) r_ram[wr_addr] <= wr_data;
        r_cell <= r_ram[w_cell_addr];
    end

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r0_de   <= 1'b0;
            r0_hs   <= SYNC_IDLE;
            r0_vs   <= SYNC_IDLE;
            r0_cur  <= 1'b0;
            r0_xcol <= '0;
            r0_yrow <= '0;
        end else begin
            r0_de   <= canDisplayImage;
            r0_hs   <= hsync_in;
            r0_vs   <= vsync_in;
            r0_cur  <= cursor_en & (w_cell_addr == cursor_addr);
            r0_xcol <= x[XB-1:0];
            r0_yrow <= y[YB-1:0];
        end
    end

    font_rom u_font (
        .clk    (clock25MHz),
        .i_addr ({r_cell.ch, r0_yrow}),
        .o_data (w_glyph)
    );

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r1_de      <= 1'b0;
            r1_hs      <= SYNC_IDLE;
            r1_vs      <= SYNC_IDLE;
            r1_curline <= 1'b0;
            r1_xcol    <= '0;
            r1_fg      <= '0;
            r1_bg      <= '0;
        end else begin
            r1_de      <= r0_de;
            r1_hs      <= r0_hs;
            r1_vs      <= r0_vs;
            r1_curline <= r0_cur & (r0_yrow >= YB'(FONT_H - 2));
            r1_xcol    <= r0_xcol;
            r1_fg      <= r_cell.fg;
            r1_bg      <= r_cell.bg;
        end
    end

    // Glyph MSB is the leftmost pixel; cursor underline XORs the bottom rows.
    assign w_pix = w_glyph[~r1_xcol] ^ (r1_curline & r_blink_vis);
    assign w_rgb = palette(w_pix ? r1_fg : r1_bg);

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= SYNC_IDLE;
            vsync <= SYNC_IDLE;
        end else begin
            red   <= r1_de ? w_rgb[11:8] : 4'h0;
            green <= r1_de ? w_rgb[7:4]  : 4'h0;
            blue  <= r1_de ? w_rgb[3:0]  : 4'h0;
            hsync <= r1_hs;
            vsync <= r1_vs;
        end
    end

    always_ff @(posedge clock25MHz) begin
        if (reset) begin
            r_vs_prev   <= SYNC_IDLE;
            r_blink_cnt <= '0;
            r_blink_vis <= 1'b1;
        end else begin
            r_vs_prev <= vsync_in;
            if (w_vs_start) begin
                if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_vis <= ~r_blink_vis;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for the text-mode pixel stage: glyph rendering, sync
// delay, reset flush, RAM bounds, read-first, cursor blink and blanking.
module tb_vga_text_renderer;

    logic        clk;
    logic        reset;
    logic [9:0]  x, y;
    logic        de, hsync_in, vsync_in;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        cursor_en;
    logic [11:0] cursor_addr;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync;

    int n_checks = 0;
    int n_fail   = 0;

    vga_text_renderer dut (
        .clock25MHz      (clk),
        .reset           (reset),
        .x               (x),
        .y               (y),
        .canDisplayImage (de),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .cursor_en       (cursor_en),
        .cursor_addr     (cursor_addr),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .hsync           (hsync),
        .vsync           (vsync)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_glyph(input logic [7:0] ch,
                                            input int row);
        logic [7:0] ga [16];
        logic [7:0] gx [16];
        ga = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
        gx = '{8'h00, 8'h00, 8'hC6, 8'hC6, 8'h6C, 8'h7C, 8'h38, 8'h38,
               8'h7C, 8'h6C, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
        if (ch == 8'h41) return ga[row];
        if (ch == 8'h58) return gx[row];
        return 8'h00;
    endfunction

    task automatic cpu_write(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 12'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic run_block(input int x0, input int y0, input int w,
                             input int h, input logic [7:0] ch,
                             input logic [11:0] fg, input logic [11:0] bg,
                             input bit inv, input string tag);
        int n, xi, yi;
        logic [7:0] g;
        logic b;
        logic [11:0] q[$];
        n = w * h;
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i >= 3) check(tag, {red, green, blue}, q[i-3]);
            if (i < n) begin
                xi = x0 + i % w;
                yi = y0 + i / w;
                x  = 10'(xi);
                y  = 10'(yi);
                de = 1'b1;
                g  = tb_glyph(ch, yi % 16);
                b  = g[7 - xi % 8] ^ (inv && (yi % 16) >= 14);
                q.push_back(b ? fg : bg);
            end else begin
                de = 1'b0;
            end
        end
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vsync_in = 1'b0;
            @(negedge clk);
            vsync_in = 1'b1;
        end
    endtask

    logic [15:0] hp, vp;

    initial begin
        reset = 1'b1; x = '0; y = '0; de = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cursor_en = 1'b0; cursor_addr = '0;
        hp = 16'b0110_1001_1100_0101;
        vp = 16'b1110_0011_0101_1010;

        repeat (2) @(negedge clk);
        check("rst_rgb", {red, green, blue}, 12'h000);
        check("rst_hs", hsync, 1'b1);
        check("rst_vs", vsync, 1'b1);
        reset = 1'b0;

        cpu_write(0, 16'h0F41);
        cpu_write(5, 16'h0F41);
        run_block(0, 0, 8, 16, 8'h41, 12'hFFF, 12'h000, 0, "A_pix");

        // Lit pixel in flight, syncs active, then reset mid-frame
        @(negedge clk);
        x = 10'd3; y = 10'd2; de = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_rgb", {red, green, blue}, 12'hFFF);
        check("pre_rst_hs", hsync, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("in_rst_rgb", {red, green, blue}, 12'h000);
        check("in_rst_hs", hsync, 1'b1);
        check("in_rst_vs", vsync, 1'b1);
        @(negedge clk);
        check("in_rst2_hs", hsync, 1'b1);
        check("in_rst2_vs", vsync, 1'b1);
        reset = 1'b0;
        de = 1'b0;
        hsync_in = hp[0]; vsync_in = vp[0];
        for (int i = 1; i < 19; i++) begin
            @(negedge clk);
            check("post_rst_rgb", {red, green, blue}, 12'h000);
            if (i < 3) begin
                check("flush_hs", hsync, 1'b1);
                check("flush_vs", vsync, 1'b1);
            end else begin
                check("dly_hs", hsync, hp[i-3]);
                check("dly_vs", vsync, vp[i-3]);
            end
            if (i < 16) begin
                hsync_in = hp[i];
                vsync_in = vp[i];
            end
        end

        cpu_write(2399, 16'h1F20);
        cpu_write(2400, 16'hFFFF);
        run_block(632, 464, 8, 16, 8'h20, 12'hFFF, 12'h00A, 0, "bg_2399");
        run_block(0, 2, 8, 1, 8'h41, 12'hFFF, 12'h000, 0, "cell0_kept");

        @(negedge clk);
        x = 10'd43; y = 10'd2; de = 1'b1;
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 16'h0F58;
        @(negedge clk);
        wr_en = 1'b0; de = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_first_old", {red, green, blue}, 12'hFFF);
        run_block(40, 0, 8, 16, 8'h58, 12'hFFF, 12'h000, 0, "X_pix");

        hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        cpu_write(81, 16'h0F20);
        cursor_en = 1'b1; cursor_addr = 12'd81;
        run_block(8, 16, 8, 16, 8'h20, 12'hFFF, 12'h000, 1, "cur_f0");
        vs_pulses(31);
        run_block(8, 16, 8, 16, 8'h20, 12'hFFF, 12'h000, 1, "cur_f31");
        vs_pulses(1);
        run_block(8, 16, 8, 16, 8'h20, 12'hFFF, 12'h000, 0, "cur_f32");
        vs_pulses(32);
        run_block(8, 16, 8, 16, 8'h20, 12'hFFF, 12'h000, 1, "cur_f64");
        run_block(0, 0, 8, 16, 8'h41, 12'hFFF, 12'h000, 0, "nocur_c0");
        cursor_en = 1'b0;

        for (int a = 0; a < 2400; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 12'(a); wr_data = 16'hFFFF;
            de = 1'b0;
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 479));
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("blank_rgb", {red, green, blue}, 12'h000);
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 479));
        end
        run_block(100, 200, 4, 1, 8'hFF, 12'hFFF, 12'hFFF, 0, "full_de1");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
